// File: rtl/multicycle_ctr_pkg.sv
// Shared encodings for the multicycle controller.
// Opcodes, state numbers and datapath select codes.
package multicycle_ctr_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [3:0] S_FETCH   = 4'd0;
  localparam logic [3:0] S_DECODE  = 4'd1;
  localparam logic [3:0] S_MEMADR  = 4'd2;
  localparam logic [3:0] S_MEMRD   = 4'd3;
  localparam logic [3:0] S_MEMWB   = 4'd4;
  localparam logic [3:0] S_MEMWR   = 4'd5;
  localparam logic [3:0] S_EXEC    = 4'd6;
  localparam logic [3:0] S_RTYPEWB = 4'd7;
  localparam logic [3:0] S_BRANCH  = 4'd8;
  localparam logic [3:0] S_JUMP    = 4'd9;
  localparam logic [3:0] S_ADDIEX  = 4'd10;
  localparam logic [3:0] S_ADDIWB  = 4'd11;

  localparam logic [1:0] SRCB_B    = 2'b00;
  localparam logic [1:0] SRCB_4    = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_IMM4 = 2'b11;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] PCSRC_ALU = 2'b00;
  localparam logic [1:0] PCSRC_OUT = 2'b01;
  localparam logic [1:0] PCSRC_JMP = 2'b10;

  // FETCH as a DECODE successor means the opcode is illegal
  function automatic logic [3:0] decode_next(
    input logic [5:0] op,
    input logic       en_addi,
    input logic       en_bne
  );
    logic [3:0] r;
    case (op)
      OP_LW, OP_SW: r = S_MEMADR;
      OP_RTYPE:     r = S_EXEC;
      OP_BEQ:       r = S_BRANCH;
      OP_J:         r = S_JUMP;
      OP_BNE:       r = en_bne ? S_BRANCH : S_FETCH;
      OP_ADDI:      r = en_addi ? S_ADDIEX : S_FETCH;
      default:      r = S_FETCH;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/multicycle_ctr_out_decode.sv
// Combinational control decode from state, opcode
// and effective memory ready.
module mc_out_decode
  import multicycle_ctr_pkg::*;
#(
  parameter logic EN_ADDI = 1'b1,
  parameter logic EN_BNE  = 1'b1
) (
  input  logic [3:0] state,
  input  logic [5:0] op,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       PCWriteCondNe,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemtoReg,
  output logic       RegDst,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] PCSource,
  output logic       illegal
);

  always_comb begin
    PCWrite       = 1'b0;
    PCWriteCond   = 1'b0;
    PCWriteCondNe = 1'b0;
    IorD          = 1'b0;
    MemRead       = 1'b0;
    MemWrite      = 1'b0;
    IRWrite       = 1'b0;
    MemtoReg      = 1'b0;
    RegDst        = 1'b0;
    RegWrite      = 1'b0;
    ALUSrcA       = 1'b0;
    ALUSrcB       = SRCB_B;
    ALUOp         = ALUOP_ADD;
    PCSource      = PCSRC_ALU;
    illegal       = 1'b0;
    unique case (state)
      S_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = SRCB_4;
        IRWrite = mem_ready;
        PCWrite = mem_ready;
      end
      S_DECODE: begin
        ALUSrcB = SRCB_IMM4;
        illegal = (decode_next(op, EN_ADDI, EN_BNE) == S_FETCH);
      end
      S_MEMADR, S_ADDIEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
      end
      S_MEMRD: begin
        IorD    = 1'b1;
        MemRead = 1'b1;
      end
      S_MEMWB: begin
        MemtoReg = 1'b1;
        RegWrite = 1'b1;
      end
      S_MEMWR: begin
        IorD     = 1'b1;
        MemWrite = 1'b1;
      end
      S_EXEC: begin
        ALUSrcA = 1'b1;
        ALUOp   = ALUOP_FUNCT;
      end
      S_RTYPEWB: begin
        RegDst   = 1'b1;
        RegWrite = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA       = 1'b1;
        ALUOp         = ALUOP_SUB;
        PCSource      = PCSRC_OUT;
        PCWriteCond   = (op == OP_BEQ);
        PCWriteCondNe = (op == OP_BNE);
      end
      S_JUMP: begin
        PCWrite  = 1'b1;
        PCSource = PCSRC_JMP;
      end
      S_ADDIWB: RegWrite = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_ctr.sv
// Multicycle MIPS-style control FSM: state register
// and next-state logic; outputs come from mc_out_decode.
module multicycle_ctr
  import multicycle_ctr_pkg::*;
#(
  parameter logic EN_ADDI  = 1'b1,
  parameter logic EN_BNE   = 1'b1,
  parameter logic MEM_WAIT = 1'b1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       PCWriteCondNe,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemtoReg,
  output logic       RegDst,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] PCSource,
  output logic       illegal,
  output logic [3:0] state_o
);

  logic [3:0] r_state;
  logic [3:0] w_next;
  logic       w_rdy;

  assign w_rdy   = MEM_WAIT ? mem_ready : 1'b1;
  assign state_o = r_state;

  always_comb begin
    w_next = S_FETCH;
    unique case (r_state)
      S_FETCH:  w_next = w_rdy ? S_DECODE : S_FETCH;
      S_DECODE: w_next = decode_next(op, EN_ADDI, EN_BNE);
      S_MEMADR: w_next = (op == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  w_next = w_rdy ? S_MEMWB : S_MEMRD;
      S_MEMWR:  w_next = w_rdy ? S_FETCH : S_MEMWR;
      S_EXEC:   w_next = S_RTYPEWB;
      S_ADDIEX: w_next = S_ADDIWB;
      default:  w_next = S_FETCH;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) r_state <= S_FETCH;
    else       r_state <= w_next;
  end

  mc_out_decode #(
    .EN_ADDI(EN_ADDI),
    .EN_BNE (EN_BNE)
  ) u_dec (
    .state        (r_state),
    .op           (op),
    .mem_ready    (w_rdy),
    .PCWrite      (PCWrite),
    .PCWriteCond  (PCWriteCond),
    .PCWriteCondNe(PCWriteCondNe),
    .IorD         (IorD),
    .MemRead      (MemRead),
    .MemWrite     (MemWrite),
    .IRWrite      (IRWrite),
    .MemtoReg     (MemtoReg),
    .RegDst       (RegDst),
    .RegWrite     (RegWrite),
    .ALUSrcA      (ALUSrcA),
    .ALUSrcB      (ALUSrcB),
    .ALUOp        (ALUOp),
    .PCSource     (PCSource),
    .illegal      (illegal)
  );

endmodule

// File: tb/tb_multicycle_ctr.sv
// Randomized bench for multicycle_ctr: three configurations
// checked against per-instruction state-sequence model.
module tb_multicycle_ctr;

  logic        clock = 1'b0;
  logic        rst_i [3];
  logic [5:0]  op_i  [3];
  logic        mr_i  [3];
  logic [3:0]  st_o  [3];
  logic [17:0] ctl_o [3];

  int n_chk = 0;
  int n_bad = 0;
  int q_st[$];
  bit q_mr[$];

  always #5 clock = ~clock;

  // k=0 defaults, k=1 no addi/bne, k=2 no memory wait
  for (genvar g = 0; g < 3; g++) begin : g_dut
    logic pcw, pcwc, pcwn, iord, mrd, mwr, irw;
    logic m2r, rdst, rw, asa, ill;
    logic [1:0] asb, aop, psrc;
    logic [3:0] st;
    multicycle_ctr #(
      .EN_ADDI (g == 1 ? 1'b0 : 1'b1),
      .EN_BNE  (g == 1 ? 1'b0 : 1'b1),
      .MEM_WAIT(g == 2 ? 1'b0 : 1'b1)
    ) u_dut (
      .clock        (clock),
      .reset        (rst_i[g]),
      .op           (op_i[g]),
      .mem_ready    (mr_i[g]),
      .PCWrite      (pcw),
      .PCWriteCond  (pcwc),
      .PCWriteCondNe(pcwn),
      .IorD         (iord),
      .MemRead      (mrd),
      .MemWrite     (mwr),
      .IRWrite      (irw),
      .MemtoReg     (m2r),
      .RegDst       (rdst),
      .RegWrite     (rw),
      .ALUSrcA      (asa),
      .ALUSrcB      (asb),
      .ALUOp        (aop),
      .PCSource     (psrc),
      .illegal      (ill),
      .state_o      (st)
    );
    assign st_o[g]  = st;
    assign ctl_o[g] = {pcw, pcwc, pcwn, iord, mrd, mwr, irw,
                       m2r, rdst, rw, asa, asb, aop, psrc, ill};
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic bit en_x(input int k);
    return k != 1;
  endfunction

  function automatic bit mwait(input int k);
    return k != 2;
  endfunction

  function automatic logic [17:0] exp_ctl(input int st,
                                          input logic [5:0] op,
                                          input bit rdy,
                                          input bit ea,
                                          input bit eb);
    logic pcw, pcwc, pcwn, iord, mrd, mwr, irw;
    logic m2r, rdst, rw, asa, ill;
    logic [1:0] asb, aop, psrc;
    bit legal;
    {pcw, pcwc, pcwn, iord, mrd, mwr, irw} = '0;
    {m2r, rdst, rw, asa, ill} = '0;
    asb = 0; aop = 0; psrc = 0;
    legal = (op == 6'h23) || (op == 6'h2b) || (op == 6'h00) ||
            (op == 6'h04) || (op == 6'h02) ||
            (op == 6'h05 && eb) || (op == 6'h08 && ea);
    case (st)
      0:  begin mrd = 1; asb = 1; irw = rdy; pcw = rdy; end
      1:  begin asb = 3; ill = !legal; end
      2:  begin asa = 1; asb = 2; end
      3:  begin iord = 1; mrd = 1; end
      4:  begin m2r = 1; rw = 1; end
      5:  begin iord = 1; mwr = 1; end
      6:  begin asa = 1; aop = 2; end
      7:  begin rdst = 1; rw = 1; end
      8:  begin
            asa = 1; aop = 1; psrc = 1;
            pcwc = (op == 6'h04); pcwn = (op == 6'h05);
          end
      9:  begin pcw = 1; psrc = 2; end
      10: begin asa = 1; asb = 2; end
      11: rw = 1;
      default: ;
    endcase
    return {pcw, pcwc, pcwn, iord, mrd, mwr, irw,
            m2r, rdst, rw, asa, asb, aop, psrc, ill};
  endfunction

  task automatic push_mem(input int st, input bit mw);
    if (mw) begin
      int n = $urandom_range(0, 3);
      repeat (n) begin q_st.push_back(st); q_mr.push_back(1'b0); end
      q_st.push_back(st); q_mr.push_back(1'b1);
    end else begin
      q_st.push_back(st); q_mr.push_back(1'b0);
    end
  endtask

  task automatic push_st(input int st, input bit mw);
    q_st.push_back(st);
    q_mr.push_back(mw ? 1'($urandom_range(0, 1)) : 1'b0);
  endtask

  // Expected state walk of one instruction, starting in FETCH
  task automatic build(input logic [5:0] op, input int k);
    bit mw = mwait(k);
    q_st.delete(); q_mr.delete();
    push_mem(0, mw);
    push_st(1, mw);
    case (op)
      6'h23: begin push_st(2, mw); push_mem(3, mw); push_st(4, mw); end
      6'h2b: begin push_st(2, mw); push_mem(5, mw); end
      6'h00: begin push_st(6, mw); push_st(7, mw); end
      6'h04: push_st(8, mw);
      6'h05: if (en_x(k)) push_st(8, mw);
      6'h02: push_st(9, mw);
      6'h08: if (en_x(k)) begin push_st(10, mw); push_st(11, mw); end
      default: ;
    endcase
  endtask

  task automatic run_instr(input int k, input logic [5:0] op);
    build(op, k);
    op_i[k] = op;
    foreach (q_st[i]) begin
      bit rdy;
      mr_i[k] = q_mr[i];
      rdy = mwait(k) ? q_mr[i] : 1'b1;
      @(negedge clock);
      check($sformatf("state k%0d op%02h #%0d", k, op, i),
            32'(st_o[k]), 32'(q_st[i]));
      check($sformatf("ctl k%0d op%02h st%0d", k, op, q_st[i]),
            32'(ctl_o[k]),
            32'(exp_ctl(q_st[i], op, rdy, en_x(k), en_x(k))));
      @(posedge clock); #1;
    end
  endtask

  task automatic do_reset(input int k);
    bit mr;
    mr = mwait(k) ? 1'($urandom_range(0, 1)) : 1'b0;
    rst_i[k] = 1'b1;
    mr_i[k]  = mr;
    @(posedge clock); #1;
    @(negedge clock);
    check($sformatf("rst state k%0d", k), 32'(st_o[k]), 32'd0);
    check($sformatf("rst ctl k%0d", k), 32'(ctl_o[k]),
          32'(exp_ctl(0, op_i[k], mwait(k) ? mr : 1'b1,
                      en_x(k), en_x(k))));
    @(posedge clock); #1;
    rst_i[k] = 1'b0;
  endtask

  // Reset arriving while a load waits for memory
  task automatic reset_in_memrd();
    op_i[0] = 6'h23;
    mr_i[0] = 1'b1;
    for (int s = 0; s < 3; s++) begin
      @(negedge clock);
      check("mrd walk", 32'(st_o[0]), 32'(s));
      @(posedge clock); #1;
    end
    mr_i[0] = 1'b0;
    @(negedge clock);
    check("mrd wait", 32'(st_o[0]), 32'd3);
    rst_i[0] = 1'b1;
    @(posedge clock); #1;
    @(negedge clock);
    check("mrd rst state", 32'(st_o[0]), 32'd0);
    check("mrd rst ctl", 32'(ctl_o[0]),
          32'(exp_ctl(0, 6'h23, 1'b0, 1'b1, 1'b1)));
    @(posedge clock); #1;
    rst_i[0] = 1'b0;
  endtask

  function automatic logic [5:0] pick_op();
    logic [5:0] tbl [7] = '{6'h23, 6'h2b, 6'h00, 6'h04,
                            6'h05, 6'h02, 6'h08};
    int r = $urandom_range(0, 9);
    if (r < 7) return tbl[r];
    return 6'($urandom_range(0, 63));
  endfunction

  initial begin
    logic [5:0] fixed [8] = '{6'h23, 6'h2b, 6'h00, 6'h04,
                              6'h05, 6'h02, 6'h08, 6'h3f};
    for (int k = 0; k < 3; k++) begin
      rst_i[k] = 1'b1; op_i[k] = 6'h00; mr_i[k] = 1'b0;
    end
    repeat (2) @(posedge clock);
    #1;
    for (int k = 0; k < 3; k++) begin
      do_reset(k);
      foreach (fixed[i]) run_instr(k, fixed[i]);
      for (int n = 0; n < 40; n++) begin
        run_instr(k, pick_op());
        if (n == 20) do_reset(k);
      end
      rst_i[k] = 1'b1;
    end
    rst_i[0] = 1'b0;
    do_reset(0);
    reset_in_memrd();
    run_instr(0, 6'h2b);
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
